// File: rtl/id_stage_pipe.sv
// -----------------------------------------------------------------------------
// id_stage_pipe : registered RV32I instruction-decode stage.
//
// Decodes one instruction per cycle from IF into the operand/field bundle that
// EX consumes. The register file is read combinationally through rf_rs1/rf_rs2
// in the same cycle, and the operands are patched from the EX and MEM result
// buses before being registered. A load sitting in EX whose destination is a
// source of the current instruction holds the instruction in IF and injects a
// bubble. A flush from EX drops the output register and refuses the IF word.
//
// Optional build macro: ID_ILLEGAL_TRAP_EN
//   defined   : adds out_illegal; unknown opcodes and OP with a funct7 other
//               than 0x00/0x20 are captured with out_illegal=1, the opcode in
//               out_ins_type and every other field 0.
//   undefined : unknown opcodes are captured as an all-zero NOP.
//
// Ports
//   clk_in, rst_n_in            clock, asynchronous active-low reset
//   rdy_in                      global enable (0: freeze all state)
//   if_valid/if_ready           IF handshake, if_pc/if_ins the offered word
//   rf_rs1/rf_rs2, rf_data1/2   combinational register-file read
//   ex_wr_en/ex_rd/ex_data      EX-stage writeback (forward source)
//   ex_is_load                  EX result not yet available (load)
//   mem_wr_en/mem_rd/mem_data   MEM-stage writeback (forward source)
//   flush                       branch/jump redirect from EX
//   ex_ready                    EX accepts the output register this cycle
//   out_*                       registered decoded instruction
// -----------------------------------------------------------------------------
module id_stage_pipe #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int OPC_W = 7
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [XLEN-1:0]  if_pc,
  input  logic [31:0]      if_ins,
  output logic [RA_W-1:0]  rf_rs1,
  output logic [RA_W-1:0]  rf_rs2,
  input  logic [XLEN-1:0]  rf_data1,
  input  logic [XLEN-1:0]  rf_data2,
  input  logic             ex_wr_en,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic [XLEN-1:0]  ex_data,
  input  logic             ex_is_load,
  input  logic             mem_wr_en,
  input  logic [RA_W-1:0]  mem_rd,
  input  logic [XLEN-1:0]  mem_data,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             out_valid,
  output logic [XLEN-1:0]  out_pc,
  output logic [RA_W-1:0]  out_r1_addr,
  output logic [RA_W-1:0]  out_r2_addr,
  output logic [RA_W-1:0]  out_rd_addr,
  output logic [XLEN-1:0]  out_r1_data,
  output logic [XLEN-1:0]  out_r2_data,
  output logic [XLEN-1:0]  out_imm,
  output logic [OPC_W-1:0] out_ins_type,
  output logic [2:0]       out_ins_details,
  output logic             out_ins_diff
`ifdef ID_ILLEGAL_TRAP_EN
  ,
  output logic             out_illegal
`endif
);

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'h03,
    OPC_OP_IMM = 7'h13,
    OPC_AUIPC  = 7'h17,
    OPC_STORE  = 7'h23,
    OPC_OP     = 7'h33,
    OPC_LUI    = 7'h37,
    OPC_BRANCH = 7'h63,
    OPC_JALR   = 7'h67,
    OPC_JAL    = 7'h6F
  } opcode_e;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [6:0]       opc;
  logic [RA_W-1:0]  dec_rs1, dec_rs2, dec_rd;
  logic [31:0]      dec_imm;
  logic [OPC_W-1:0] dec_type;
  logic [2:0]       dec_f3;
  logic             dec_diff;
  logic             dec_keep_pc;   // 0 for NOP/illegal captures: pc is zeroed too
`ifdef ID_ILLEGAL_TRAP_EN
  logic             dec_ill;
`endif

  assign opc = if_ins[6:0];

  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that left
    // one unassigned would infer a latch.
    dec_rs1     = '0;
    dec_rs2     = '0;
    dec_rd      = '0;
    dec_imm     = '0;
    dec_type    = '0;
    dec_f3      = '0;
    dec_diff    = 1'b0;
    dec_keep_pc = 1'b1;
`ifdef ID_ILLEGAL_TRAP_EN
    dec_ill     = 1'b0;
`endif
    case (opc)
      OPC_LUI, OPC_AUIPC: begin
        dec_type = OPC_W'(opc);
        dec_rd   = RA_W'(if_ins[11:7]);
        dec_imm  = {if_ins[31:12], 12'b0};
      end
      OPC_JAL: begin
        dec_type = OPC_W'(opc);
        dec_rd   = RA_W'(if_ins[11:7]);
        dec_imm  = {{11{if_ins[31]}}, if_ins[31], if_ins[19:12], if_ins[20],
                    if_ins[30:21], 1'b0};
      end
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
        dec_type = OPC_W'(opc);
        dec_rd   = RA_W'(if_ins[11:7]);
        dec_rs1  = RA_W'(if_ins[19:15]);
        dec_f3   = if_ins[14:12];
        dec_imm  = {{20{if_ins[31]}}, if_ins[31:20]};
        dec_diff = (opc == OPC_OP_IMM) && if_ins[30];
      end
      OPC_BRANCH: begin
        dec_type = OPC_W'(opc);
        dec_rs1  = RA_W'(if_ins[19:15]);
        dec_rs2  = RA_W'(if_ins[24:20]);
        dec_f3   = if_ins[14:12];
        dec_imm  = {{19{if_ins[31]}}, if_ins[31], if_ins[7], if_ins[30:25],
                    if_ins[11:8], 1'b0};
      end
      OPC_STORE: begin
        dec_type = OPC_W'(opc);
        dec_rs1  = RA_W'(if_ins[19:15]);
        dec_rs2  = RA_W'(if_ins[24:20]);
        dec_f3   = if_ins[14:12];
        dec_imm  = {{20{if_ins[31]}}, if_ins[31:25], if_ins[11:7]};
      end
      OPC_OP: begin
`ifdef ID_ILLEGAL_TRAP_EN
        if (if_ins[31:25] != 7'h00 && if_ins[31:25] != 7'h20) begin
          dec_ill     = 1'b1;
          dec_type    = OPC_W'(opc);
          dec_keep_pc = 1'b0;
        end else
`endif
        begin
          dec_type = OPC_W'(opc);
          dec_rd   = RA_W'(if_ins[11:7]);
          dec_rs1  = RA_W'(if_ins[19:15]);
          dec_rs2  = RA_W'(if_ins[24:20]);
          dec_f3   = if_ins[14:12];
          dec_diff = if_ins[30];
        end
      end
      default: begin
`ifdef ID_ILLEGAL_TRAP_EN
        dec_ill  = 1'b1;
        dec_type = OPC_W'(opc);
`endif
        dec_keep_pc = 1'b0;
      end
    endcase
  end

  assign rf_rs1 = dec_rs1;
  assign rf_rs2 = dec_rs2;

  // ---------------------------------------------------------------------------
  // Operand forwarding: EX beats MEM beats the register file; x0 is always 0.
  // A load in EX has no result yet, so it never forwards (the hazard stalls).
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] fwd1, fwd2;

  assign fwd1 = (dec_rs1 == '0)                                   ? '0       :
                (ex_wr_en && !ex_is_load && ex_rd == dec_rs1)     ? ex_data  :
                (mem_wr_en && mem_rd == dec_rs1)                  ? mem_data :
                                                                    rf_data1;
  assign fwd2 = (dec_rs2 == '0)                                   ? '0       :
                (ex_wr_en && !ex_is_load && ex_rd == dec_rs2)     ? ex_data  :
                (mem_wr_en && mem_rd == dec_rs2)                  ? mem_data :
                                                                    rf_data2;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic valid_q, valid_d;
  logic hz, adv, capture;

  // Unused sources are forced to 0 and ex_rd != 0, so they never match here.
  assign hz       = ex_wr_en && ex_is_load && (ex_rd != '0) &&
                    ((dec_rs1 == ex_rd) || (dec_rs2 == ex_rd));
  assign adv      = !valid_q || ex_ready;
  assign if_ready = rst_n_in && rdy_in && adv && !hz && !flush;
  assign capture  = if_valid && if_ready;

  always_comb begin
    valid_d = valid_q;
    if (rdy_in) begin
      if (flush)        valid_d = 1'b0;
      else if (capture) valid_d = 1'b1;
      else if (adv)     valid_d = 1'b0;   // bubble; data fields keep old value
    end
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]  pc_q, r1_data_q, r2_data_q, imm_q;
  logic [RA_W-1:0]  r1_addr_q, r2_addr_q, rd_addr_q;
  logic [OPC_W-1:0] type_q;
  logic [2:0]       f3_q;
  logic             diff_q;
`ifdef ID_ILLEGAL_TRAP_EN
  logic             ill_q;
`endif

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      r1_addr_q <= '0;
      r2_addr_q <= '0;
      rd_addr_q <= '0;
      r1_data_q <= '0;
      r2_data_q <= '0;
      imm_q     <= '0;
      type_q    <= '0;
      f3_q      <= '0;
      diff_q    <= 1'b0;
`ifdef ID_ILLEGAL_TRAP_EN
      ill_q     <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      if (capture) begin
        pc_q      <= dec_keep_pc ? if_pc : '0;
        r1_addr_q <= dec_rs1;
        r2_addr_q <= dec_rs2;
        rd_addr_q <= dec_rd;
        r1_data_q <= fwd1;
        r2_data_q <= fwd2;
        imm_q     <= XLEN'($signed(dec_imm));
        type_q    <= dec_type;
        f3_q      <= dec_f3;
        diff_q    <= dec_diff;
`ifdef ID_ILLEGAL_TRAP_EN
        ill_q     <= dec_ill;
`endif
      end
    end
  end

  assign out_valid       = valid_q;
  assign out_pc          = pc_q;
  assign out_r1_addr     = r1_addr_q;
  assign out_r2_addr     = r2_addr_q;
  assign out_rd_addr     = rd_addr_q;
  assign out_r1_data     = r1_data_q;
  assign out_r2_data     = r2_data_q;
  assign out_imm         = imm_q;
  assign out_ins_type    = type_q;
  assign out_ins_details = f3_q;
  assign out_ins_diff    = diff_q;
`ifdef ID_ILLEGAL_TRAP_EN
  assign out_illegal     = ill_q;
`endif

endmodule
